// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default widths/period and the ramp state type.
package pwm_pkg;

  localparam int DEF_DUTY_W        = 4;
  localparam int DEF_PERIOD_CYCLES = 2000;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; period_tick marks the last cycle.
module pwm_period_timer
  import pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
  input  logic clk_1MHz,
  input  logic reset,
  output logic period_tick
);

  localparam int CW =
    (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign period_tick = (cnt_q == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty ramp: steps pulse_width toward an accepted target at
// period boundaries. RAMP_BYPASS_EN adds a bypass input for one-tick jumps.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int STEP_PERIODS  = 4,
  parameter int DUTY_W        = DEF_DUTY_W,
  parameter int MAX_DUTY      = 15
) (
  input  logic              clk_1MHz,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] pulse_width,
  output logic              ramp_busy,
  output logic              period_tick
`ifdef RAMP_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int SW =
    (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [DUTY_W-1:0] MAX_C = DUTY_W'(MAX_DUTY);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] pw_q, pw_d;
  logic [SW-1:0]     step_q, step_d;
  logic              byp_q, byp_d;
  logic [DUTY_W-1:0] tgt_in;
  logic              byp_in;

`ifdef RAMP_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  pwm_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk_1MHz   (clk_1MHz),
    .reset      (reset),
    .period_tick(period_tick)
  );

  assign tgt_in = (target_duty > MAX_C) ? MAX_C : target_duty;

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      pw_q    <= '0;
      step_q  <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      pw_q    <= pw_d;
      step_q  <= step_d;
      byp_q   <= byp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pw_d    = pw_q;
    step_d  = step_q;
    byp_d   = byp_q;
    unique case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d  = tgt_in;
          step_d = '0;
          byp_d  = byp_in;
          if (byp_in || (tgt_in != pw_q)) begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (period_tick) begin
          if (byp_q || byp_in) begin
            pw_d    = tgt_q;
            byp_d   = 1'b0;
            state_d = IDLE;
          end else if (step_q == STEP_LAST) begin
            step_d = '0;
            pw_d = (tgt_q > pw_q) ? pw_q + 1'b1
                                  : pw_q - 1'b1;
            if (pw_d == tgt_q) begin
              state_d = IDLE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pulse_width  = pw_q;
  assign ramp_busy    = (state_q == RAMP);
  assign target_ready = (state_q == IDLE) && !reset;

endmodule
